// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//   Shares one single-port data memory between two requesters. Port 0 is the core
//   load/store unit and port 1 is the debug/loader port. Each port has a valid/ready
//   request channel and a one-cycle response pulse. One access is in flight at a time:
//   IDLE (arbitrate + accept) -> ISSUE (drive memory bus) -> RESP (pulse response).
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   reqN_valid/ready           request handshake for port N (ready only in IDLE)
//   reqN_write/addr/wdata      request payload, sampled on the handshake edge
//   rspN_valid/rdata           completion pulse; rdata is load data, 0 for stores
//   mem_read/mem_write         registered memory strobes, high only in ISSUE
//   endereco/write_data        registered memory address / store data
//   read_data                  combinational memory read data
module data_memory_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter bit          ROUND_ROBIN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] endereco,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } state_e;

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic                  wr_q, wr_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] endereco_q, endereco_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic grant0, grant1;
    logic rsp_active;

    // Arbitration. Gated by rst_n so nothing handshakes while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && (state_q == StIdle)) begin
            if (req0_valid && req1_valid) begin
                if (ROUND_ROBIN) begin
                    // Contention goes to the port that did not win last time.
                    grant0 = last_grant_q;
                    grant1 = ~last_grant_q;
                end else begin
                    grant0 = 1'b1;
                end
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Next-state logic. endereco_q/write_data_q double as the request latch and the
    // registered memory bus, so they are loaded on the handshake edge and valid in ISSUE.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        rdata_d      = rdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        endereco_d   = '0;
        write_data_d = '0;

        unique case (state_q)
            StIdle: begin
                if (grant0 || grant1) begin
                    owner_d      = grant1;
                    last_grant_d = grant1;
                    wr_d         = grant1 ? req1_write : req0_write;
                    endereco_d   = grant1 ? req1_addr  : req0_addr;
                    write_data_d = grant1 ? req1_wdata : req0_wdata;
                    mem_write_d  = wr_d;
                    mem_read_d   = ~wr_d;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                // Loads capture memory here; stores respond with zero data.
                rdata_d = wr_q ? '0 : read_data;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            wr_q         <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            endereco_q   <= '0;
            write_data_q <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            endereco_q   <= endereco_d;
            write_data_q <= write_data_d;
            rdata_q      <= rdata_d;
        end
    end

    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign endereco   = endereco_q;
    assign write_data = write_data_q;

    // Reset asserted during RESP suppresses the pulse, so the access is aborted cleanly.
    assign rsp_active = rst_n && (state_q == StResp);
    assign rsp0_valid = rsp_active && !owner_q;
    assign rsp1_valid = rsp_active && owner_q;
    assign rsp0_rdata = rsp0_valid ? rdata_q : '0;
    assign rsp1_rdata = rsp1_valid ? rdata_q : '0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req0_write = 1'b0;
    logic [31:0] req0_addr = '0, req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_write = 1'b0;
    logic [31:0] req1_addr = '0, req1_wdata = '0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] endereco, write_data, read_data;

    // Second instance, fixed priority, both ports always requesting.
    logic        b_valid = 1'b1;
    logic        b_zero = 1'b0;
    logic [31:0] b_word = '0;
    logic        b_ready0, b_ready1, b_rsp0, b_rsp1, b_mrd, b_mwr;
    logic [31:0] b_rdata0, b_rdata1, b_addr, b_wdata;

    always #5 clk = ~clk;

    data_memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .endereco(endereco),
        .write_data(write_data), .read_data(read_data)
    );

    data_memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_valid), .req0_ready(b_ready0), .req0_write(b_zero),
        .req0_addr(b_word), .req0_wdata(b_word),
        .rsp0_valid(b_rsp0), .rsp0_rdata(b_rdata0),
        .req1_valid(b_valid), .req1_ready(b_ready1), .req1_write(b_zero),
        .req1_addr(b_word), .req1_wdata(b_word),
        .rsp1_valid(b_rsp1), .rsp1_rdata(b_rdata1),
        .mem_read(b_mrd), .mem_write(b_mwr), .endereco(b_addr),
        .write_data(b_wdata), .read_data(b_word)
    );

    // Behavioural data memory: 64 words, combinational read, write on posedge.
    logic [31:0] tmem [64];
    assign read_data = mem_read ? tmem[endereco[5:0]] : 32'h0;
    always @(posedge clk) if (mem_write) tmem[endereco[5:0]] <= write_data;

    function automatic logic [31:0] init_val(input int i);
        return (i == 0) ? 32'h0000_0FFF : 32'h1000_0000 + 32'(i * 7);
    endfunction

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    typedef struct { int cyc; logic wr; logic [31:0] addr; logic [31:0] wdata; } iss_t;
    typedef struct { int cyc; int port; logic [31:0] rdata; } rsp_t;
    iss_t iq[$];
    rsp_t rq[$];

    // Reference model state: a transaction-level view of the arbiter.
    logic [31:0] ref_mem [64];
    int busy = 0;
    int last = 1;

    // Monitor: compares the memory bus and responses against queued expectations.
    always @(negedge clk) begin
        logic ei, e0, e1;
        logic [31:0] ed;
        if (iq.size() > 0 && iq[0].cyc < cyc) begin
            chk("issue_missed", 32'(iq[0].cyc), 32'(cyc));
            void'(iq.pop_front());
        end
        ei = (iq.size() > 0) && (iq[0].cyc == cyc);
        chk("mem_read", {31'b0, mem_read}, {31'b0, ei && !iq[0].wr});
        chk("mem_write", {31'b0, mem_write}, {31'b0, ei && iq[0].wr});
        if (ei) begin
            chk("endereco", endereco, iq[0].addr);
            chk("write_data", write_data, iq[0].wdata);
            void'(iq.pop_front());
        end
        if (rq.size() > 0 && rq[0].cyc < cyc) begin
            chk("rsp_missed", 32'(rq[0].cyc), 32'(cyc));
            void'(rq.pop_front());
        end
        e0 = (rq.size() > 0) && (rq[0].cyc == cyc) && (rq[0].port == 0);
        e1 = (rq.size() > 0) && (rq[0].cyc == cyc) && (rq[0].port == 1);
        ed = (e0 || e1) ? rq[0].rdata : 32'h0;
        chk("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, e0});
        chk("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, e1});
        chk("rsp0_rdata", rsp0_rdata, e0 ? ed : 32'h0);
        chk("rsp1_rdata", rsp1_rdata, e1 ? ed : 32'h0);
        if (e0 || e1) void'(rq.pop_front());
        chk("excl_mem", {31'b0, mem_read & mem_write}, 32'h0);
        chk("excl_ready", {31'b0, req0_ready & req1_ready}, 32'h0);
        chk("excl_rsp", {31'b0, rsp0_valid & rsp1_valid}, 32'h0);
    end

    // Fixed-priority instance: port 1 must starve under permanent contention.
    int n_r0 = 0, n_r1 = 0, n_s0 = 0, n_s1 = 0;
    logic fp_done = 1'b0;
    initial begin
        @(posedge rst_n);
        repeat (30) begin
            @(negedge clk);
            n_r0 += int'(b_ready0);
            n_r1 += int'(b_ready1);
            n_s0 += int'(b_rsp0);
            n_s1 += int'(b_rsp1);
        end
        chk("fp_ready0_count", 32'(n_r0), 32'd10);
        chk("fp_ready1_count", 32'(n_r1), 32'd0);
        chk("fp_rsp0_count", 32'(n_s0), 32'd10);
        chk("fp_rsp1_count", 32'(n_s1), 32'd0);
        fp_done = 1'b1;
    end

    // One cycle: apply inputs just after posedge, predict the grant, check ready at negedge.
    task automatic step(input logic rst,
                        input logic v0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic v1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        int g;
        logic w;
        logic [31:0] a, d, rd;
        rst_n = rst;
        req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1;
        g = -1;
        if (!rst) begin
            rq.delete();
            busy = 0;
            last = 1;
        end else if (busy > 0) begin
            busy--;
        end else if (v0 && v1) begin
            g = (last == 1) ? 0 : 1;
        end else if (v0) begin
            g = 0;
        end else if (v1) begin
            g = 1;
        end
        @(negedge clk);
        chk("req0_ready", {31'b0, req0_ready}, {31'b0, g == 0});
        chk("req1_ready", {31'b0, req1_ready}, {31'b0, g == 1});
        if (g >= 0) begin
            w = (g == 1) ? w1 : w0;
            a = (g == 1) ? a1 : a0;
            d = (g == 1) ? d1 : d0;
            iq.push_back('{cyc: cyc + 1, wr: w, addr: a, wdata: d});
            rd = w ? 32'h0 : ref_mem[a[5:0]];
            if (w) ref_mem[a[5:0]] = d;
            rq.push_back('{cyc: cyc + 2, port: g, rdata: rd});
            last = g;
            busy = 2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            tmem[i] = init_val(i);
            ref_mem[i] = init_val(i);
        end

        // Reset held with both ports requesting.
        step(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
        chk("reset_endereco", endereco, 32'h0);
        chk("reset_write_data", write_data, 32'h0);

        // Lone load from address 0.
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(3);

        // Port 1 store 111 to address 1, then load it back.
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1, 32'd111);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1, 32'h0);
        idle(3);

        // Continuous contention: grants alternate every three cycles.
        for (int i = 0; i < 12; i++)
            step(1'b1, 1'b1, 1'b0, 32'(i), 32'h0, 1'b1, 1'b0, 32'(i + 20), 32'h0);
        idle(3);

        // Randomised traffic with full-width addresses and data.
        for (int i = 0; i < 300; i++)
            step(1'b1,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
        idle(4);

        // Reset during the RESP cycle of a load aborts it; next request is normal.
        step(1'b1, 1'b1, 1'b0, 32'h5, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h9, 32'h0);
        idle(4);

        chk("rsp_queue_drained", 32'(rq.size()), 32'd0);
        chk("iss_queue_drained", 32'(iq.size()), 32'd0);
        chk("fp_window_done", {31'b0, fp_done}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
